instr_fetch_queue: RTL

//  Fetch-side front end: generates sequential PCs, issues instruction reads to main memory over a
//  req/gnt/rvalid handshake, and buffers returned words with their PCs in a DEPTH-entry FIFO.

---
 rtl/instr_fetch_queue_if.sv | 30 +++
 rtl/instr_fetch_queue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue_if.sv
// Instruction-fetch bus bundle: memory read port (req/gnt/rvalid) and the
// decode-side valid/ready queue head. master = fetch queue, slave = memory/decode side.
interface instr_fetch_queue_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [ILEN-1:0] mem_rdata;
   logic            out_valid;
   logic [ILEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic            out_ready;

   modport master (
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output out_valid, out_instr, out_pc,
      input  out_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  out_valid, out_instr, out_pc,
      output out_ready
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited instruction reads,
// and a DEPTH-entry {instr, pc} FIFO toward decode with branch-redirect flush.
module instr_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       halt,
   input  logic                       redirect_en,
   input  logic [XLEN-1:0]            redirect_pc,
   instr_fetch_queue_if.master        bus,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t          state, state_next;
   logic            req;
   logic [XLEN-1:0] addr_q, pc_tag, target;
   logic [CW-1:0]   count, outstanding, drop_cnt;
   logic [CW-1:0]   outstanding_next, held_next, count_next;
   logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_next;
   logic [ILEN-1:0] data_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [ILEN-1:0] out_instr_q, head_instr;
   logic [XLEN-1:0] out_pc_q, head_pc;
   logic            fire_gnt, drop, push, pop, credit;

   assign target   = redirect_pc & ~XLEN'(3);
   assign req      = (state == REQ);
   assign fire_gnt = req & bus.mem_gnt;
   assign drop     = bus.mem_rvalid && (drop_cnt != '0);
   assign push     = bus.mem_rvalid && (drop_cnt == '0) && !redirect_en;
   assign pop      = (count != '0) && bus.out_ready && !redirect_en;

   assign outstanding_next = outstanding + CW'(fire_gnt) - CW'(bus.mem_rvalid);
   // Entries held next cycle ignoring this cycle's pop: a pop frees credit one cycle late.
   assign held_next   = redirect_en ? '0 : count + CW'(push);
   assign count_next  = held_next - CW'(pop);
   assign credit      = ({1'b0, held_next} + {1'b0, outstanding_next}) < (CW+1)'(DEPTH);
   assign rd_ptr_next = rd_ptr + PW'(pop);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = HOLD;
      if (!halt && credit) state_next = REQ;
   end

   // Next head: the incoming word when the queue would otherwise drain empty.
   always_comb begin
      head_instr = out_instr_q;
      head_pc    = out_pc_q;
      if (count_next != '0) begin
         if (count == CW'(pop)) begin
            head_instr = bus.mem_rdata;
            head_pc    = pc_tag;
         end else begin
            head_instr = data_mem[rd_ptr_next];
            head_pc    = pc_mem[rd_ptr_next];
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= RESET_PC;
         pc_tag      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         state       <= state_next;
         outstanding <= outstanding_next;
         count       <= count_next;
         rd_ptr      <= rd_ptr_next;
         out_instr_q <= head_instr;
         out_pc_q    <= head_pc;
         if (redirect_en) begin
            addr_q   <= target;
            pc_tag   <= target;
            drop_cnt <= outstanding_next;
            wr_ptr   <= rd_ptr_next;
         end else begin
            if (fire_gnt) addr_q <= addr_q + XLEN'(4);
            if (push) begin
               pc_tag <= pc_tag + XLEN'(4);
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (drop) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   // NOTE: storage has no reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= bus.mem_rdata;
         pc_mem[wr_ptr]   <= pc_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push && !pop) assert (count != CW'(DEPTH));
   end

   assign bus.mem_req   = req;
   assign bus.mem_addr  = addr_q;
   assign bus.out_valid = (count != '0);
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign occupancy     = count;
endmodule
